// File: rtl/aes_pkg.sv
// AES shared types, tables and round datapath functions.
// Byte n of a 128-bit block sits at bits [127-8n -: 8], column-major.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [2047:0] SBOX_T = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Index 0 is never used; the tail pads the table to 16 entries.
  localparam logic [0:15][7:0] RCON = {
    8'h8d, 8'h01, 8'h02, 8'h04,
    8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic int nr_of(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

  function automatic logic [7:0] sbox(
    input logic [7:0] b
  );
    return SBOX_T[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(
    input logic [7:0] b
  );
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul3(
    input logic [7:0] b
  );
    return xtime(b) ^ b;
  endfunction

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(
    input logic [31:0] w
  );
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] sub_bytes(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++)
      o[127-8*n -: 8] = sbox(s[127-8*n -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] =
          s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(
    input logic [127:0] s
  );
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] =
        gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3;
      o[119-32*c -: 8] =
        a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3;
      o[111-32*c -: 8] =
        a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3);
      o[103-32*c -: 8] =
        gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One key-expansion step: four new words from the last NK words.
// The round key is words 4..7 of the window extended by the new words.
module aes_key_step
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic [NK-1:0][31:0] win,
  input  logic [2:0]          wmod,
  input  logic [7:0]          rcon,
  output logic [127:0]        rk,
  output logic [NK-1:0][31:0] win_nxt,
  output logic                rc_used
);

  logic [NK+3:0][31:0] ext;
  logic [31:0] t;
  int m;

  always_comb begin
    ext = '0;
    t = '0;
    m = 0;
    rc_used = 1'b0;
    for (int k = 0; k < NK; k++)
      ext[k] = win[k];
    for (int j = 0; j < 4; j++) begin
      m = int'(wmod) + j;
      if (m >= NK)
        m = m - NK;
      t = ext[NK+j-1];
      if (m == 0) begin
        t = sub_word(rot_word(t)) ^ {rcon, 24'h0};
        rc_used = 1'b1;
      end else if (NK == 8 && m == 4) begin
        t = sub_word(t);
      end
      ext[NK+j] = ext[j] ^ t;
    end
    for (int k = 0; k < NK; k++)
      win_nxt[k] = ext[k+4];
    rk = {ext[4], ext[5], ext[6], ext[7]};
  end

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES encryptor, one round per clock, keys expanded on the fly.
// valid/ready on both sides; result held in DONE until taken.
module aes_enc_iter
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        plaintext,
  input  logic [KEY_BITS-1:0] key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        ciphertext,
  output logic                busy
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = nr_of(KEY_BITS);
  localparam logic [5:0] LAST_IDX =
    6'(NK + 4 * (NR - 1));

  if (KEY_BITS != 128 && KEY_BITS != 192 &&
      KEY_BITS != 256) begin : g_bad
    $error("aes_enc_iter: KEY_BITS must be 128/192/256");
  end

  fsm_t st, st_nxt;
  logic [127:0] state_reg, rnd, sr, rk;
  logic [NK-1:0][31:0] win, win_nxt;
  logic [2:0] wmod;
  logic [3:0] rc, round, m4;
  logic [5:0] word_idx;
  logic rc_used, accept, last, kadv;

  aes_key_step #(.NK(NK)) u_key (
    .win     (win),
    .wmod    (wmod),
    .rcon    (RCON[rc]),
    .rk      (rk),
    .win_nxt (win_nxt),
    .rc_used (rc_used)
  );

  assign last = (round == 4'(NR));
  assign kadv = (word_idx != LAST_IDX);
  assign accept = in_valid & in_ready;
  assign m4 = {1'b0, wmod} + 4'd4;

  always_comb begin
    sr = shift_rows(sub_bytes(state_reg));
    rnd = (last ? sr : mix_columns(sr)) ^ rk;
  end

  always_comb begin
    st_nxt = st;
    in_ready = 1'b0;
    unique case (st)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) st_nxt = RUN;
      end
      RUN: if (last) st_nxt = DONE;
      DONE: begin
        in_ready = out_ready;
        if (out_ready)
          st_nxt = in_valid ? RUN : IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      state_reg <= '0;
      win <= '0;
      wmod <= '0;
      rc <= '0;
      word_idx <= '0;
      round <= '0;
    end else begin
      st <= st_nxt;
      if (accept) begin
        state_reg <= plaintext ^
          key[KEY_BITS-1 -: 128];
        for (int k = 0; k < NK; k++)
          win[k] <= key[KEY_BITS-1-32*k -: 32];
        wmod <= '0;
        rc <= 4'd1;
        word_idx <= 6'(NK);
        round <= 4'd1;
      end else if (st == RUN) begin
        state_reg <= rnd;
        round <= round + 4'd1;
        // The last round needs no further key words.
        if (kadv) begin
          win <= win_nxt;
          wmod <= (m4 >= 4'(NK)) ?
            3'(m4 - 4'(NK)) : 3'(m4);
          rc <= rc + {3'b0, rc_used};
          word_idx <= word_idx + 6'd4;
        end
      end
    end
  end

  assign out_valid = (st == DONE);
  assign busy = (st == RUN);
  assign ciphertext =
    (st == DONE) ? state_reg : '0;

endmodule
